// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding and operation select codes.
package alu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } seq_state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_seq_fa.sv
// Single-bit full-adder cell with built-in operand-B inversion for subtraction.
module fullAdder (
    input  logic A,
    input  logic B,
    input  logic cin,
    input  logic sub,
    output logic sum,
    output logic cout
);

    logic b_eff;

    always_comb begin
        b_eff = B ^ sub;
        sum   = A ^ b_eff ^ cin;
        cout  = (A & b_eff) | (cin & (A ^ b_eff));
    end

endmodule

// File: rtl/serial_addsub_seq.sv
// Bit-serial add/subtract sequencer: feeds one fullAdder cell LSB first for WIDTH cycles.
module serial_addsub_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             sub_q, sub_d;
    logic             cy_q, cy_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             last_bit;
    logic             fa_sum;
    logic             fa_cout;

    fullAdder u_fa (
        .A    (a_sh_q[0]),
        .B    (b_sh_q[0]),
        .cin  (cy_q),
        .sub  (sub_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign accept   = start && (state_q != S_RUN);
    assign last_bit = (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = accept ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    // Datapath: capture on accept, one bit per RUN cycle.
    // Subtract seeds the carry with 1 so the cell's inverted B becomes two's complement.
    always_comb begin
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        result_d = result_q;
        sub_d    = sub_q;
        cy_d     = cy_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        if (accept) begin
            a_sh_d   = a;
            b_sh_d   = b;
            sub_d    = sub;
            cy_d     = sub;
            cnt_d    = '0;
            result_d = '0;
        end else if (state_q == S_RUN) begin
            result_d = {fa_sum, result_q[WIDTH-1:1]};
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            cy_d     = fa_cout;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last_bit) begin
                carry_d = fa_cout;
                ovf_d   = cy_q ^ fa_cout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            result_q <= '0;
            sub_q    <= OP_ADD;
            cy_q     <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            result_q <= result_d;
            sub_q    <= sub_d;
            cy_q     <= cy_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result   = result_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Self-checking bench for serial_addsub_seq: directed cases plus random ops against an arithmetic model.
module tb_serial_addsub_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_addsub_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry    (carry),
        .overflow (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Golden model from plain integer arithmetic
    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         output logic [W-1:0] r, output logic c, output logic v);
        int ux, uy, ix, iy, sv;
        ux = int'(x);
        uy = int'(y);
        ix = x[W-1] ? ux - (1 << W) : ux;
        iy = y[W-1] ? uy - (1 << W) : uy;
        if (s) begin
            r  = W'(ux - uy);
            c  = (ux >= uy);
            sv = ix - iy;
        end else begin
            r  = W'(ux + uy);
            c  = ((ux + uy) >= (1 << W));
            sv = ix + iy;
        end
        v = (sv > (1 << (W - 1)) - 1) || (sv < -(1 << (W - 1)));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        a     = x;
        b     = y;
        sub   = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits for done (bounded), scrambling the operand inputs meanwhile.
    task automatic finish_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic s, input int elapsed);
        logic [W-1:0] er;
        logic         ec, ev;
        int           n;
        bit           seen;
        bit           busy_ok;
        model(x, y, s, er, ec, ev);
        n       = elapsed;
        seen    = 1'b0;
        busy_ok = 1'b1;
        for (int i = 0; i < 3 * W && !seen; i++) begin
            if (!busy) busy_ok = 1'b0;
            a   = W'($urandom);
            b   = W'($urandom);
            sub = 1'($urandom);
            tick();
            n++;
            if (done) seen = 1'b1;
        end
        chk({tag, "/done_seen"}, 32'(seen), 32'd1);
        chk({tag, "/latency"}, 32'(n), 32'(W));
        chk({tag, "/busy_run"}, 32'(busy_ok), 32'd1);
        chk({tag, "/busy_done"}, 32'(busy), 32'd0);
        chk({tag, "/result"}, 32'(result), 32'(er));
        chk({tag, "/carry"}, 32'(carry), 32'(ec));
        chk({tag, "/ovf"}, 32'(overflow), 32'(ev));
    endtask

    initial begin
        logic [W-1:0] x, y, hold_r;
        logic         s;
        bit           no_done;

        reset = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst/busy", 32'(busy), 32'd0);
        chk("rst/done", 32'(done), 32'd0);
        chk("rst/result", 32'(result), 32'd0);
        chk("rst/carry", 32'(carry), 32'd0);
        chk("rst/ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        tick();

        // Directed arithmetic cases
        launch(8'h35, 8'h4A, 1'b0); finish_op("add35_4a", 8'h35, 8'h4A, 1'b0, 0);
        hold_r = result;
        tick();
        chk("pulse/done_fall", 32'(done), 32'd0);
        chk("pulse/idle_busy", 32'(busy), 32'd0);
        chk("pulse/hold_result", 32'(result), 32'(hold_r));
        tick();
        launch(8'h7F, 8'h01, 1'b0); finish_op("add7f_01", 8'h7F, 8'h01, 1'b0, 0); tick();
        launch(8'hFF, 8'h01, 1'b0); finish_op("addff_01", 8'hFF, 8'h01, 1'b0, 0); tick();
        launch(8'h05, 8'h03, 1'b1); finish_op("sub05_03", 8'h05, 8'h03, 1'b1, 0); tick();
        launch(8'h03, 8'h05, 1'b1); finish_op("sub03_05", 8'h03, 8'h05, 1'b1, 0); tick();
        launch(8'h80, 8'h01, 1'b1); finish_op("sub80_01", 8'h80, 8'h01, 1'b1, 0); tick();

        // Start pulsed mid-RUN with new operands must be ignored
        launch(8'h12, 8'h34, 1'b0);
        tick();
        tick();
        a     = 8'hAA;
        b     = 8'h55;
        sub   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("midrun/busy", 32'(busy), 32'd1);
        finish_op("midrun", 8'h12, 8'h34, 1'b0, 3);
        tick();

        // Reset during RUN aborts without a done pulse
        launch(8'h5A, 8'h33, 1'b0);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort/busy", 32'(busy), 32'd0);
        chk("abort/done", 32'(done), 32'd0);
        chk("abort/result", 32'(result), 32'd0);
        chk("abort/carry", 32'(carry), 32'd0);
        chk("abort/ovf", 32'(overflow), 32'd0);
        no_done = 1'b1;
        for (int i = 0; i < W + 3; i++) begin
            tick();
            if (done || busy) no_done = 1'b0;
        end
        chk("abort/quiet", 32'(no_done), 32'd1);

        // Back-to-back: start asserted while in DONE
        launch(8'hC8, 8'h64, 1'b0); finish_op("b2b_1", 8'hC8, 8'h64, 1'b0, 0);
        launch(8'h10, 8'h20, 1'b1);
        chk("b2b/rerun_busy", 32'(busy), 32'd1);
        chk("b2b/result_cleared", 32'(result), 32'd0);
        finish_op("b2b_2", 8'h10, 8'h20, 1'b1, 0);

        // Random ops, both modes, random gaps (gap 0 exercises DONE->RUN)
        for (int k = 0; k < 200; k++) begin
            x = W'($urandom);
            y = W'($urandom);
            s = 1'($urandom);
            launch(x, y, s);
            finish_op($sformatf("rnd%0d", k), x, y, s, 0);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
